// File: rtl/reciever_framer.sv
// rtl/reciever_framer.sv - serial frame aligner/checker with a show-ahead output queue
// Hunts for HEADSTART bit-by-bit, then checks START/END positionally around the index and payload fields.
module reciever_framer #(
  parameter int          PAYLOAD_WIDTH   = 32,
  parameter int          REFERENCE_WIDTH = 16,
  parameter logic [7:0]  FRAME_HEADSTART = 8'hA5,
  parameter logic [7:0]  FRAME_START     = 8'h7E,
  parameter logic [7:0]  FRAME_END       = 8'h81,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               write,
  input  logic                               data_stream,
  output logic [PAYLOAD_WIDTH-1:0]           payload,
  output logic [REFERENCE_WIDTH-1:0]         index,
  output logic                               valid,
  input  logic                               ready,
  output logic                               frame_err,
  output logic                               overflow,
  output logic                               locked,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);
  localparam int PAY_BYTES = PAYLOAD_WIDTH / 8;
  localparam int REF_BYTES = REFERENCE_WIDTH / 8;
  localparam int MAX_BYTES = (PAY_BYTES > REF_BYTES) ? PAY_BYTES : REF_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W     = REFERENCE_WIDTH + PAYLOAD_WIDTH;

  typedef enum logic [2:0] {HUNT, HEAD, MARK, DATA, TAIL} state_t;

  state_t                       state, state_next;
  logic                         write_q, write_edge;
  logic [7:0]                   sh, cand;
  logic [2:0]                   bit_cnt;
  logic [CNT_W-1:0]             byte_cnt;
  logic [REFERENCE_WIDTH-1:0]   idx_sh;
  logic [PAYLOAD_WIDTH-1:0]     pay_sh;
  logic [REFERENCE_WIDTH+7:0]   idx_ext;
  logic [PAYLOAD_WIDTH+7:0]     pay_ext;
  logic                         err_next, ovf_next, push, pop, full, byte_done;

  logic [ENT_W-1:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [LVL_W-1:0]             count;

  assign write_edge = write & ~write_q;
  assign cand       = MSB_FIRST ? {sh[6:0], data_stream} : {data_stream, sh[7:1]};
  assign byte_done  = write_edge && (bit_cnt == 3'd7);
  assign idx_ext    = {idx_sh, cand};
  assign pay_ext    = {pay_sh, cand};

  assign valid  = (count != '0);
  assign full   = (count == LVL_W'(FIFO_DEPTH));
  assign pop    = valid & ready;
  assign level  = count;
  assign locked = (state != HUNT);
  assign {index, payload} = mem[rd_ptr];

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    ovf_next   = 1'b0;
    push       = 1'b0;
    case (state)
      HUNT: if (write_edge && cand == FRAME_HEADSTART) state_next = HEAD;
      HEAD: if (byte_done && byte_cnt == CNT_W'(REF_BYTES - 1)) state_next = MARK;
      MARK: if (byte_done) begin
        if (cand == FRAME_START) begin
          state_next = DATA;
        end else begin
          state_next = HUNT;
          err_next   = 1'b1;
        end
      end
      DATA: if (byte_done && byte_cnt == CNT_W'(PAY_BYTES - 1)) state_next = TAIL;
      TAIL: if (byte_done) begin
        state_next = HUNT;
        if (cand != FRAME_END) err_next = 1'b1;
        else if (full && !pop) ovf_next = 1'b1;
        else push = 1'b1;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= HUNT;
      write_q   <= 1'b0;
      sh        <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      idx_sh    <= '0;
      pay_sh    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      write_q   <= write;
      frame_err <= err_next;
      overflow  <= ovf_next;
      if (write_edge) begin
        sh <= cand;
        // Byte alignment restarts at the bit after HEADSTART is recognised
        if (state == HUNT) begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (byte_done && state == HEAD) begin
        idx_sh   <= idx_ext[REFERENCE_WIDTH-1:0];
        byte_cnt <= (byte_cnt == CNT_W'(REF_BYTES - 1)) ? '0 : byte_cnt + CNT_W'(1);
      end else if (byte_done && state == DATA) begin
        pay_sh   <= pay_ext[PAYLOAD_WIDTH-1:0];
        byte_cnt <= (byte_cnt == CNT_W'(PAY_BYTES - 1)) ? '0 : byte_cnt + CNT_W'(1);
      end
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

  // Queue storage needs no reset; valid gates its contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {idx_sh, pay_sh};
  end
endmodule

// File: tb/tb_reciever_framer.sv
// tb/tb_reciever_framer.sv - directed bench driving MSB-first and LSB-first framers with the same frames
module tb_reciever_framer;
  logic        clk = 1'b0;
  logic        clr, write, ready, dm, dl;
  logic [31:0] pay_m, pay_l;
  logic [15:0] idx_m, idx_l;
  logic        valid_m, valid_l, err_m, err_l, ovf_m, ovf_l, lk_m, lk_l;
  logic [2:0]  lvl_m, lvl_l;
  int          checks = 0;
  int          failures = 0;
  int          gap = 0;

  always #5 clk = ~clk;

  reciever_framer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clr(clr), .write(write), .data_stream(dm), .payload(pay_m), .index(idx_m),
    .valid(valid_m), .ready(ready), .frame_err(err_m), .overflow(ovf_m), .locked(lk_m), .level(lvl_m));

  reciever_framer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .write(write), .data_stream(dl), .payload(pay_l), .index(idx_l),
    .valid(valid_l), .ready(ready), .frame_err(err_l), .overflow(ovf_l), .locked(lk_l), .level(lvl_l));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Packed as {valid, frame_err, overflow, locked, level, index, payload}; head data ignored while empty
  task automatic expect_out(input string tag, input logic v, input logic e, input logic o,
                            input logic l, input logic [2:0] lvl, input logic [15:0] idx,
                            input logic [31:0] pay);
    logic [54:0] exp, mask;
    exp  = {v, e, o, l, lvl, idx, pay};
    mask = v ? {55{1'b1}} : {7'h7f, 48'h0};
    check({tag, "_msb"}, 64'({valid_m, err_m, ovf_m, lk_m, lvl_m, idx_m, pay_m} & mask), 64'(exp & mask));
    check({tag, "_lsb"}, 64'({valid_l, err_l, ovf_l, lk_l, lvl_l, idx_l, pay_l} & mask), 64'(exp & mask));
  endtask

  task automatic send_bit(input logic bm, input logic bl);
    @(negedge clk);
    dm = bm; dl = bl; write = 1'b1;
    repeat (1 + gap) @(negedge clk);
    write = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_part(input logic [7:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(b[7-i], b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_part(b, 0, 7);
  endtask

  task automatic send_body(input logic [15:0] idx, input logic [31:0] pay,
                           input logic [7:0] mark, input logic [7:0] fend);
    send_byte(idx[15:8]); send_byte(idx[7:0]); send_byte(mark);
    for (int k = 3; k >= 0; k--) send_byte(pay[8*k +: 8]);
    send_byte(fend);
  endtask

  task automatic send_frame(input logic [15:0] idx, input logic [31:0] pay);
    send_byte(8'hA5);
    send_body(idx, pay, 8'h7E, 8'h81);
  endtask

  initial begin
    clr = 1'b1; write = 1'b0; ready = 1'b1; dm = 1'b0; dl = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);

    send_frame(16'h1234, 32'hDEADBEEF);
    expect_out("aligned", 1, 0, 0, 0, 3'd1, 16'h1234, 32'hDEADBEEF);
    @(negedge clk);
    expect_out("aligned_pop", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);

    ready = 1'b0; gap = 3;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    expect_out("leadin_hunt", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    send_byte(8'hA5);
    expect_out("leadin_locked", 0, 0, 0, 1, 3'd0, 16'h0, 32'h0);
    send_body(16'h1234, 32'hDEADBEEF, 8'h7E, 8'h81);
    expect_out("leadin_frame", 1, 0, 0, 0, 3'd1, 16'h1234, 32'hDEADBEEF);
    gap = 0; ready = 1'b1;
    @(negedge clk);
    expect_out("leadin_pop", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);

    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h7F);
    expect_out("bad_marker", 0, 1, 0, 0, 3'd0, 16'h0, 32'h0);
    @(negedge clk);
    expect_out("bad_marker_end", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    send_frame(16'hABCD, 32'h01020304);
    expect_out("after_bad", 1, 0, 0, 0, 3'd1, 16'hABCD, 32'h01020304);
    @(negedge clk);

    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_frame(16'h0100 + 16'(k), {4{8'h10 + 8'(k)}});
      expect_out($sformatf("bp_fill%0d", k), 1, 0, 0, 0, 3'(k + 1), 16'h0100, 32'h10101010);
    end
    send_frame(16'h0104, 32'h14141414);
    expect_out("bp_overflow", 1, 0, 1, 0, 3'd4, 16'h0100, 32'h10101010);
    @(negedge clk);
    expect_out("bp_ovf_end", 1, 0, 0, 0, 3'd4, 16'h0100, 32'h10101010);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("bp_drain%0d", k), 1, 0, 0, 0, 3'(4 - k), 16'h0100 + 16'(k), {4{8'h10 + 8'(k)}});
      @(negedge clk);
    end
    expect_out("bp_empty", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);

    ready = 1'b0;
    send_frame(16'h5555, 32'h12345678);
    expect_out("mr_queued", 1, 0, 0, 0, 3'd1, 16'h5555, 32'h12345678);
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h7E);
    send_byte(8'hDE); send_part(8'hAD, 0, 3);
    expect_out("mr_in_data", 1, 0, 0, 1, 3'd1, 16'h5555, 32'h12345678);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    expect_out("mr_reset", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    send_part(8'hAD, 4, 7); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h81);
    expect_out("mr_rest_ignored", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);
    ready = 1'b1;
    send_frame(16'hC0DE, 32'hCAFEF00D);
    expect_out("mr_next", 1, 0, 0, 0, 3'd1, 16'hC0DE, 32'hCAFEF00D);
    @(negedge clk);
    expect_out("mr_next_pop", 0, 0, 0, 0, 3'd0, 16'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
